tap_ctrl: RTL and testbench
===========================

# tap_ctrl

IEEE 1149.1-style TAP controller that sequences the JTAG data-register block (`dr`). It runs the 16-state TAP FSM from TMS and owns the instruction register. It drives `dr`'s CAPTUREDR/SHIFTDR/UPDATEDR strobes and one-hot instruction selects. It also multiplexes the IR, bypass and DR serial outputs onto the TDO pin.

## Interface
- IR_WIDTH, 4: instruction register width; opcodes below assume 4.
- IR_CAPTURE, 4'b0101: pattern loaded into IR shift stage in Capture-IR (bits[1:0] must be 2'b01).
- IR_RESET, 4'h1: IR value after reset/Test-Logic-Reset (IDCODE).

- TCK  in  1  JTAG clock; all logic on TCK.
- TRST_N  in  1  asynchronous, active-low reset.
- TMS  in  1  mode select, sampled on posedge TCK.
- TDI  in  1  serial data in, sampled on posedge TCK.
- ID_REG_TDO  in  1  ID register serial out from `dr` (already negedge-registered).
- BSR_TDO  in  1  BSR/usercode chain serial out from `dr` (already negedge-registered).
- TDO  out  1  serial data out.
- TDO_EN  out  1  output enable; high only while in Shift-IR/Shift-DR.
- CAPTUREDR / SHIFTDR / UPDATEDR  out  1 each  high while FSM is in Capture-DR / Shift-DR / Update-DR.
- IDCODE_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, USERCODE_SELECT  out  1 each  one-hot decode of the active IR.
- STATE  out  4  current TAP state encoding (debug).

## Operation
- FSM: the standard 16 states and TMS transitions (TLR, RTI, Select-DR, Capture-DR, Shift-DR, Exit1-DR, Pause-DR, Exit2-DR, Update-DR, plus IR mirror). From any state, 5 consecutive TMS=1 reach TLR.
- Strobes are Moore outputs of STATE. `dr` acts on the posedge that leaves the corresponding state.
- IR shift stage:
  - Capture-IR: loads IR_CAPTURE.
  - Shift-IR: `{TDI, ir_sh[IR_WIDTH-1:1]}`, LSB out first.
  - Pause/Exit states: holds.
- Active IR:
  - Update-IR: loads ir_sh at the posedge leaving the state.
  - TLR: forced to IR_RESET.
- Opcode decode:
  - EXTEST 4'h0, IDCODE 4'h1, SAMPLE 4'h2, INTEST 4'h3, USERCODE 4'h4, BYPASS 4'hF.
  - Any other opcode: all selects low (bypass when enabled).
  - At most one select high at any time.
- TDO mux:
  - Shift-IR: ir_tdo, a negedge register of ir_sh[0].
  - Shift-DR, IDCODE: ID_REG_TDO.
  - Shift-DR, SAMPLE/EXTEST/INTEST/USERCODE: BSR_TDO.
  - Shift-DR, bypass: byp_tdo.
  - Otherwise: 0.
- Reset (TRST_N low, any time, including mid-shift):
  - STATE=TLR, IR=IR_RESET (IDCODE_SELECT=1, others 0).
  - ir_sh=IR_CAPTURE, strobes 0, TDO=0, TDO_EN=0.

## Timing
- State register updates on posedge TCK. TDO_EN and ir_tdo/byp_tdo update on negedge TCK.
- Selects change only at the posedge leaving Update-IR or entering TLR. They stay stable through all DR states.
- Shift length N in Shift-IR yields the last N TDI bits in the IR, LSB = earliest.
- TDO is valid from the negedge after entering Shift-xR. The first TDO bit is the captured LSB.
- Exit1-xR -> Update-xR without Pause is legal. Pause dwell of any length preserves the shift contents.

## Configuration
- `TAP_BYPASS_EN` defined:
  - 1-bit bypass register: cleared to 0 in Capture-DR, loads TDI in Shift-DR.
  - byp_tdo is a negedge copy of it.
  - Selected by BYPASS and all undefined opcodes; TDI-to-TDO latency is 1 TCK.
- Not defined:
  - No bypass register.
  - BYPASS/undefined opcodes drive TDO=0 during Shift-DR.
  - TDO_EN behaviour is unchanged.

## Structure
- Shared package `jtag_pkg`: 4-bit TAP state encodings (TLR=4'hF, RTI=4'hC, … standard 1149.1 codes), opcode localparams, IR_WIDTH default.
- Sub-module `tap_fsm`: pure state register plus next-state logic (TCK, TRST_N, TMS -> STATE). `tap_ctrl` holds the IR, decode and TDO mux.

## Test plan
- Hold TRST_N=0, then release, 1 TCK with TMS=0 -> STATE=RTI, IDCODE_SELECT=1, others 0, TDO_EN=0.
- From RTI, TMS=1,1,1,1,1 -> STATE=TLR after 5th posedge; repeat from Shift-DR and Pause-IR with the same result.
- IR scan shifting TDI=0,0,1,0 (LSB first, opcode 4'h4) -> TDO emits 1,0,1,0 (capture 0101). After Update-IR, USERCODE_SELECT=1; next DR scan pulses CAPTUREDR for exactly 1 TCK, then SHIFTDR for N cycles.
- IR=IDCODE, DR scan 8 shifts -> TDO follows ID_REG_TDO each bit, TDO_EN high exactly during Shift-DR.
- With TAP_BYPASS_EN, IR=4'hF (also 4'h9): DR shift TDI=1,0,1,1 -> TDO=0,1,0,1. Without the macro -> TDO=0,0,0,0.
- Assert TRST_N mid Shift-IR after 2 bits -> immediate TLR, IR=4'h1, TDO=0, partial IR discarded.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: standard 1149.1 TAP state codes, instruction opcodes
// and the default instruction-register width.
package jtag_pkg;

    localparam int IR_WIDTH_DEF = 4;

    typedef enum logic [3:0] {
        EXIT2_DR   = 4'h0,
        EXIT1_DR   = 4'h1,
        SHIFT_DR   = 4'h2,
        PAUSE_DR   = 4'h3,
        SELECT_IR  = 4'h4,
        UPDATE_DR  = 4'h5,
        CAPTURE_DR = 4'h6,
        SELECT_DR  = 4'h7,
        EXIT2_IR   = 4'h8,
        EXIT1_IR   = 4'h9,
        SHIFT_IR   = 4'hA,
        PAUSE_IR   = 4'hB,
        RTI        = 4'hC,
        UPDATE_IR  = 4'hD,
        CAPTURE_IR = 4'hE,
        TLR        = 4'hF
    } tap_state_e;

    localparam logic [3:0] OP_EXTEST   = 4'h0;
    localparam logic [3:0] OP_IDCODE   = 4'h1;
    localparam logic [3:0] OP_SAMPLE   = 4'h2;
    localparam logic [3:0] OP_INTEST   = 4'h3;
    localparam logic [3:0] OP_USERCODE = 4'h4;
    localparam logic [3:0] OP_BYPASS   = 4'hF;

endpackage

// File: rtl/tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine: state register and TMS next-state
// logic only; the next state is exported so the IR can act on entry to TLR.
module tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST_N,
    input  logic       TMS,
    output logic [3:0] STATE,
    output logic [3:0] NEXT_STATE
);

    tap_state_e r_state;
    tap_state_e w_next;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) r_state <= TLR;
        else         r_state <= w_next;
    end

    // NOTE: w_next gets a default before the case so no latch can be inferred.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            TLR:        w_next = TMS ? TLR       : RTI;
            RTI:        w_next = TMS ? SELECT_DR : RTI;
            SELECT_DR:  w_next = TMS ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR: w_next = TMS ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:   w_next = TMS ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:   w_next = TMS ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:   w_next = TMS ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:   w_next = TMS ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:  w_next = TMS ? SELECT_DR : RTI;
            SELECT_IR:  w_next = TMS ? TLR       : CAPTURE_IR;
            CAPTURE_IR: w_next = TMS ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:   w_next = TMS ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:   w_next = TMS ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:   w_next = TMS ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:   w_next = TMS ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:  w_next = TMS ? SELECT_DR : RTI;
        endcase
    end

    always_comb begin
        STATE      = r_state;
        NEXT_STATE = w_next;
    end

endmodule

// File: rtl/tap_ctrl.sv
// TAP controller: instruction register, opcode decode, DR strobes and TDO mux.
// Define TAP_BYPASS_EN to include the 1-bit bypass register.
module tap_ctrl
    import jtag_pkg::*;
#(
    parameter int                  IR_WIDTH   = IR_WIDTH_DEF,
    parameter logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(4'b0101),
    parameter logic [IR_WIDTH-1:0] IR_RESET   = IR_WIDTH'(4'h1)
) (
    input  logic       TCK,
    input  logic       TRST_N,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       ID_REG_TDO,
    input  logic       BSR_TDO,
    output logic       TDO,
    output logic       TDO_EN,
    output logic       CAPTUREDR,
    output logic       SHIFTDR,
    output logic       UPDATEDR,
    output logic       IDCODE_SELECT,
    output logic       SAMPLE_SELECT,
    output logic       EXTEST_SELECT,
    output logic       INTEST_SELECT,
    output logic       USERCODE_SELECT,
    output logic [3:0] STATE
);

    logic [3:0]          w_state;
    logic [3:0]          w_next;
    logic [IR_WIDTH-1:0] r_ir_sh;
    logic [IR_WIDTH-1:0] r_ir;
    logic                r_ir_tdo;
    logic                r_shift_ir;
    logic                r_shift_dr;
    logic                w_byp_tdo;
    logic                w_bsr_sel;

    tap_fsm u_fsm (
        .TCK        (TCK),
        .TRST_N     (TRST_N),
        .TMS        (TMS),
        .STATE      (w_state),
        .NEXT_STATE (w_next)
    );

    assign STATE = w_state;

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_ir_sh <= IR_CAPTURE;
        end else if (w_state == CAPTURE_IR) begin
            r_ir_sh <= IR_CAPTURE;
        end else if (w_state == SHIFT_IR) begin
            r_ir_sh <= {TDI, r_ir_sh[IR_WIDTH-1:1]};
        end
    end

    // Only TLR and Select-IR can enter TLR, never Update-IR, so the priority is moot.
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_ir <= IR_RESET;
        end else if (w_next == TLR) begin
            r_ir <= IR_RESET;
        end else if (w_state == UPDATE_IR) begin
            r_ir <= r_ir_sh;
        end
    end

    always_comb begin
        CAPTUREDR = (w_state == CAPTURE_DR);
        SHIFTDR   = (w_state == SHIFT_DR);
        UPDATEDR  = (w_state == UPDATE_DR);
    end

    always_comb begin
        IDCODE_SELECT   = (r_ir == IR_WIDTH'(OP_IDCODE));
        SAMPLE_SELECT   = (r_ir == IR_WIDTH'(OP_SAMPLE));
        EXTEST_SELECT   = (r_ir == IR_WIDTH'(OP_EXTEST));
        INTEST_SELECT   = (r_ir == IR_WIDTH'(OP_INTEST));
        USERCODE_SELECT = (r_ir == IR_WIDTH'(OP_USERCODE));
        w_bsr_sel       = SAMPLE_SELECT | EXTEST_SELECT | INTEST_SELECT | USERCODE_SELECT;
    end

    // Falling-edge stage so TDO changes half a cycle away from the TDI/TMS sample edge.
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            r_ir_tdo   <= 1'b0;
            r_shift_ir <= 1'b0;
            r_shift_dr <= 1'b0;
        end else begin
            r_ir_tdo   <= r_ir_sh[0];
            r_shift_ir <= (w_state == SHIFT_IR);
            r_shift_dr <= (w_state == SHIFT_DR);
        end
    end

`ifdef TAP_BYPASS_EN
    logic r_byp;
    logic r_byp_tdo;

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N)                    r_byp <= 1'b0;
        else if (w_state == CAPTURE_DR) r_byp <= 1'b0;
        else if (w_state == SHIFT_DR)   r_byp <= TDI;
    end

    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) r_byp_tdo <= 1'b0;
        else         r_byp_tdo <= r_byp;
    end

    assign w_byp_tdo = r_byp_tdo;
`else
    assign w_byp_tdo = 1'b0;
`endif

    always_comb begin
        TDO_EN = r_shift_ir | r_shift_dr;
        TDO    = 1'b0;
        if (r_shift_ir) begin
            TDO = r_ir_tdo;
        end else if (r_shift_dr) begin
            if (IDCODE_SELECT)  TDO = ID_REG_TDO;
            else if (w_bsr_sel) TDO = BSR_TDO;
            else                TDO = w_byp_tdo;
        end
    end

endmodule

// File: tb/tb_tap_ctrl.sv
// Self-checking bench for tap_ctrl: directed scans plus a random TMS/TDI walk
// compared against a table-driven reference model of the TAP.
module tb_tap_ctrl;

    logic       TCK = 1'b0;
    logic       TRST_N = 1'b0;
    logic       TMS = 1'b0;
    logic       TDI = 1'b0;
    logic       ID_REG_TDO = 1'b0;
    logic       BSR_TDO = 1'b0;
    logic       TDO, TDO_EN, CAPTUREDR, SHIFTDR, UPDATEDR;
    logic       IDCODE_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, USERCODE_SELECT;
    logic [3:0] STATE;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: TMS transition table plus IR / bypass contents
    int         tab0[16];
    int         tab1[16];
    int         m_state;
    logic [3:0] m_sh;
    logic [3:0] m_ir;
    logic       m_byp;

    wire [4:0] dut_sel = {IDCODE_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, USERCODE_SELECT};

    tap_ctrl dut (
        .TCK             (TCK),
        .TRST_N          (TRST_N),
        .TMS             (TMS),
        .TDI             (TDI),
        .ID_REG_TDO      (ID_REG_TDO),
        .BSR_TDO         (BSR_TDO),
        .TDO             (TDO),
        .TDO_EN          (TDO_EN),
        .CAPTUREDR       (CAPTUREDR),
        .SHIFTDR         (SHIFTDR),
        .UPDATEDR        (UPDATEDR),
        .IDCODE_SELECT   (IDCODE_SELECT),
        .SAMPLE_SELECT   (SAMPLE_SELECT),
        .EXTEST_SELECT   (EXTEST_SELECT),
        .INTEST_SELECT   (INTEST_SELECT),
        .USERCODE_SELECT (USERCODE_SELECT),
        .STATE           (STATE)
    );

    always #5 TCK = ~TCK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic build_table();
        tab0[15] = 12; tab1[15] = 15;
        tab0[12] = 12; tab1[12] = 7;
        tab0[7]  = 6;  tab1[7]  = 4;
        tab0[6]  = 2;  tab1[6]  = 1;
        tab0[2]  = 2;  tab1[2]  = 1;
        tab0[1]  = 3;  tab1[1]  = 5;
        tab0[3]  = 3;  tab1[3]  = 0;
        tab0[0]  = 2;  tab1[0]  = 5;
        tab0[5]  = 12; tab1[5]  = 7;
        tab0[4]  = 14; tab1[4]  = 15;
        tab0[14] = 10; tab1[14] = 9;
        tab0[10] = 10; tab1[10] = 9;
        tab0[9]  = 11; tab1[9]  = 13;
        tab0[11] = 11; tab1[11] = 8;
        tab0[8]  = 10; tab1[8]  = 13;
        tab0[13] = 12; tab1[13] = 7;
    endtask

    task automatic model_reset();
        m_state = 15;
        m_ir    = 4'h1;
        m_sh    = 4'b0101;
        m_byp   = 1'b0;
    endtask

    // Expected selects ordered {IDCODE, SAMPLE, EXTEST, INTEST, USERCODE}
    function automatic logic [4:0] exp_sel(input logic [3:0] op);
        case (op)
            4'h1:    return 5'b10000;
            4'h2:    return 5'b01000;
            4'h0:    return 5'b00100;
            4'h3:    return 5'b00010;
            4'h4:    return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic exp_tdo();
        logic [4:0] s;
        s = exp_sel(m_ir);
        if (m_state == 10) return m_sh[0];
        if (m_state == 2) begin
            if (s[4])      return ID_REG_TDO;
            if (|s[3:0])   return BSR_TDO;
`ifdef TAP_BYPASS_EN
            return m_byp;
`else
            return 1'b0;
`endif
        end
        return 1'b0;
    endfunction

    // One TCK: drive inputs, advance the model at the rising edge, return just after the falling edge.
    task automatic tick(input logic tms, input logic tdi);
        int nxt;
        TMS        = tms;
        TDI        = tdi;
        ID_REG_TDO = 1'($urandom);
        BSR_TDO    = 1'($urandom);
        @(posedge TCK);
        if (m_state == 14)      m_sh  = 4'b0101;
        else if (m_state == 10) m_sh  = {tdi, m_sh[3:1]};
        else if (m_state == 13) m_ir  = m_sh;
        else if (m_state == 6)  m_byp = 1'b0;
        else if (m_state == 2)  m_byp = tdi;
        nxt = tms ? tab1[m_state] : tab0[m_state];
        if (nxt == 15) m_ir = 4'h1;
        m_state = nxt;
        @(negedge TCK);
        #1;
    endtask

    // From RTI: full IR scan of op, collecting the four TDO bits seen in Shift-IR; ends in RTI.
    task automatic shift_ir(input logic [3:0] op, output logic [3:0] tdo_bits);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tdo_bits[0] = TDO;
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, op[i]);
            if (i < 3) tdo_bits[i+1] = TDO;
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // From RTI: DR scan of n bits; returns TDO, ID/BSR stimulus per bit and strobe/enable counts.
    task automatic shift_dr(input int n, input logic [15:0] tdi_bits,
                            output logic [15:0] tdo_bits, output logic [15:0] id_bits,
                            output logic [15:0] bsr_bits, output int cap_cnt,
                            output int sh_cnt, output int en_cnt);
        tdo_bits = '0; id_bits = '0; bsr_bits = '0;
        cap_cnt = 0; sh_cnt = 0; en_cnt = 0;
        for (int i = 0; i < n + 5; i++) begin
            if (i == 0)          tick(1'b1, 1'b0);
            else if (i < 3)      tick(1'b0, 1'b0);
            else if (i < n + 3)  tick(i == n + 2, tdi_bits[i-3]);
            else if (i == n + 3) tick(1'b1, 1'b0);
            else                 tick(1'b0, 1'b0);
            cap_cnt += int'(CAPTUREDR);
            sh_cnt  += int'(SHIFTDR);
            en_cnt  += int'(TDO_EN);
            if (i >= 2 && i < n + 2) begin
                tdo_bits[i-2] = TDO;
                id_bits[i-2]  = ID_REG_TDO;
                bsr_bits[i-2] = BSR_TDO;
            end
        end
    endtask

    task automatic test_reset();
        TRST_N = 1'b0;
        model_reset();
        repeat (2) @(negedge TCK);
        #1;
        n_cmp++;
        if (STATE !== 4'hF) begin n_err++; $display("FAIL reset_state: got %h want F", STATE); end
        n_cmp++;
        if ({TDO, TDO_EN, CAPTUREDR, SHIFTDR, UPDATEDR} !== 5'b0) begin
            n_err++; $display("FAIL reset_outputs: got %b want 00000", {TDO, TDO_EN, CAPTUREDR, SHIFTDR, UPDATEDR});
        end
        n_cmp++;
        if (dut_sel !== 5'b10000) begin n_err++; $display("FAIL reset_selects: got %b want 10000", dut_sel); end
        TRST_N = 1'b1;
        tick(1'b0, 1'b0);
        n_cmp++;
        if (STATE !== 4'hC) begin n_err++; $display("FAIL reset_to_rti: got %h want C", STATE); end
        n_cmp++;
        if (dut_sel !== 5'b10000 || TDO_EN !== 1'b0) begin
            n_err++; $display("FAIL rti_after_reset: sel %b en %b want 10000 0", dut_sel, TDO_EN);
        end
    endtask

    task automatic test_force_tlr();
        repeat (5) tick(1'b1, 1'b0);
        n_cmp++;
        if (STATE !== 4'hF) begin n_err++; $display("FAIL tlr_from_rti: got %h want F", STATE); end
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        n_cmp++;
        if (STATE !== 4'h2) begin n_err++; $display("FAIL reach_shift_dr: got %h want 2", STATE); end
        repeat (5) tick(1'b1, 1'b0);
        n_cmp++;
        if (STATE !== 4'hF) begin n_err++; $display("FAIL tlr_from_shift_dr: got %h want F", STATE); end
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        n_cmp++;
        if (STATE !== 4'hB) begin n_err++; $display("FAIL reach_pause_ir: got %h want B", STATE); end
        repeat (5) tick(1'b1, 1'b0);
        n_cmp++;
        if (STATE !== 4'hF) begin n_err++; $display("FAIL tlr_from_pause_ir: got %h want F", STATE); end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_usercode_scan();
        logic [3:0]  t;
        logic [15:0] tdo, idv, bsrv;
        int          cap, sh, en;
        shift_ir(4'h4, t);
        n_cmp++;
        if (t !== 4'b0101) begin n_err++; $display("FAIL ir_capture_tdo: got %b want 0101", t); end
        n_cmp++;
        if (dut_sel !== 5'b00001) begin n_err++; $display("FAIL usercode_select: got %b want 00001", dut_sel); end
        shift_dr(6, 16'(($urandom)), tdo, idv, bsrv, cap, sh, en);
        n_cmp++;
        if (cap !== 1 || sh !== 6 || en !== 6) begin
            n_err++; $display("FAIL dr_strobes: cap %0d sh %0d en %0d want 1 6 6", cap, sh, en);
        end
        n_cmp++;
        if (tdo[5:0] !== bsrv[5:0]) begin n_err++; $display("FAIL usercode_tdo: got %b want %b", tdo[5:0], bsrv[5:0]); end
        n_cmp++;
        if (dut_sel !== 5'b00001) begin n_err++; $display("FAIL select_stable: got %b want 00001", dut_sel); end
    endtask

    task automatic test_idcode_dr();
        logic [3:0]  t;
        logic [15:0] tdo, idv, bsrv;
        int          cap, sh, en;
        shift_ir(4'h1, t);
        n_cmp++;
        if (dut_sel !== 5'b10000) begin n_err++; $display("FAIL idcode_select: got %b want 10000", dut_sel); end
        shift_dr(8, 16'($urandom), tdo, idv, bsrv, cap, sh, en);
        n_cmp++;
        if (tdo[7:0] !== idv[7:0]) begin n_err++; $display("FAIL idcode_tdo: got %b want %b", tdo[7:0], idv[7:0]); end
        n_cmp++;
        if (en !== 8 || sh !== 8) begin n_err++; $display("FAIL idcode_tdo_en: en %0d sh %0d want 8 8", en, sh); end
    endtask

    task automatic test_bypass();
        logic [3:0]  t;
        logic [15:0] tdo, idv, bsrv;
        int          cap, sh, en;
        logic [3:0]  ops [2];
        logic [3:0]  want;
        ops[0] = 4'hF;
        ops[1] = 4'h9;
`ifdef TAP_BYPASS_EN
        want = 4'b1010;
`else
        want = 4'b0000;
`endif
        for (int k = 0; k < 2; k++) begin
            shift_ir(ops[k], t);
            n_cmp++;
            if (dut_sel !== 5'b00000) begin n_err++; $display("FAIL bypass_select op %h: got %b want 00000", ops[k], dut_sel); end
            shift_dr(4, 16'b1101, tdo, idv, bsrv, cap, sh, en);
            n_cmp++;
            if (tdo[3:0] !== want) begin n_err++; $display("FAIL bypass_tdo op %h: got %b want %b", ops[k], tdo[3:0], want); end
        end
    endtask

    task automatic test_trst_mid_shift();
        logic [3:0] t;
        shift_ir(4'h4, t);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b0, 1'b1); tick(1'b0, 1'b1);
        TRST_N = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (STATE !== 4'hF || TDO !== 1'b0 || TDO_EN !== 1'b0) begin
            n_err++; $display("FAIL trst_async: state %h tdo %b en %b want F 0 0", STATE, TDO, TDO_EN);
        end
        n_cmp++;
        if (dut_sel !== 5'b10000) begin n_err++; $display("FAIL trst_ir: got %b want 10000", dut_sel); end
        @(posedge TCK);
        @(negedge TCK);
        #1;
        TRST_N = 1'b1;
        tick(1'b0, 1'b0);
        n_cmp++;
        if (STATE !== 4'hC || dut_sel !== 5'b10000) begin
            n_err++; $display("FAIL trst_release: state %h sel %b want C 10000", STATE, dut_sel);
        end
        shift_ir(4'h2, t);
        n_cmp++;
        if (t !== 4'b0101 || dut_sel !== 5'b01000) begin
            n_err++; $display("FAIL post_trst_scan: tdo %b sel %b want 0101 01000", t, dut_sel);
        end
    endtask

    task automatic test_random_walk(input int cycles);
        logic tms;
        for (int i = 0; i < cycles; i++) begin
            tms = ($urandom_range(0, 9) < 4);
            tick(tms, 1'($urandom));
            n_cmp++;
            if (STATE !== 4'(m_state)) begin n_err++; $display("FAIL walk_state cyc %0d: got %h want %h", i, STATE, m_state); end
            n_cmp++;
            if ({CAPTUREDR, SHIFTDR, UPDATEDR} !== {m_state == 6, m_state == 2, m_state == 5}) begin
                n_err++; $display("FAIL walk_strobes cyc %0d: got %b state %h", i, {CAPTUREDR, SHIFTDR, UPDATEDR}, m_state);
            end
            n_cmp++;
            if (TDO_EN !== (m_state == 2 || m_state == 10)) begin
                n_err++; $display("FAIL walk_tdo_en cyc %0d: got %b state %h", i, TDO_EN, m_state);
            end
            n_cmp++;
            if (TDO !== exp_tdo()) begin n_err++; $display("FAIL walk_tdo cyc %0d: got %b want %b", i, TDO, exp_tdo()); end
            n_cmp++;
            if (dut_sel !== exp_sel(m_ir)) begin
                n_err++; $display("FAIL walk_select cyc %0d: got %b want %b", i, dut_sel, exp_sel(m_ir));
            end
        end
    endtask

    initial begin
        build_table();
        model_reset();
        test_reset();
        test_force_tlr();
        test_usercode_scan();
        test_idcode_dr();
        test_bypass();
        test_trst_mid_shift();
        test_random_walk(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
